// File: rtl/cell_line_fetch_pkg.sv
// Shared timing constants and fetch FSM encoding for the automaton VGA display path.
package automata_vga_pkg;
    localparam int unsigned H_ACTIVE      = 1280;
    localparam int unsigned H_TOTAL       = 1688;
    localparam int unsigned V_ACTIVE      = 1024;
    localparam int unsigned V_TOTAL       = 1066;
    localparam int unsigned WORD_W        = 20;
    localparam int unsigned WORDS_PER_ROW = 64;
    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned RD_LATENCY    = 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;
endpackage

// File: rtl/cell_line_fetch_if.sv
// Cell RAM port B read bus: the fetcher is master, the RAM is slave.
interface cell_line_fetch_if;
    import automata_vga_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [WORD_W-1:0] mem_q;

    modport master (output mem_addr, output mem_rd, input mem_q);
    modport slave  (input mem_addr, input mem_rd, output mem_q);
endinterface

// File: rtl/cell_line_fetch_line_buffer_pp.sv
// Ping-pong line store: captures write the back buffer while the display reads the front one.
module line_buffer_pp
    import automata_vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [5:0]        wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [5:0]        rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic              front_valid,
    input  logic              swap,
    input  logic              invalidate
);
    logic [WORD_W-1:0] buf_mem [2][WORDS_PER_ROW];
    logic              sel_q, sel_d;
    logic [1:0]        valid_q, valid_d;

    always_comb begin
        sel_d   = sel_q;
        valid_d = valid_q;
        if (swap) begin
            sel_d           = ~sel_q;
            valid_d         = '0;
            valid_d[~sel_q] = 1'b1;
        end else if (invalidate) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[~sel_q][wr_idx] <= wr_data;
        end
    end

    assign rd_data     = buf_mem[sel_q][rd_idx];
    assign front_valid = valid_q[sel_q];
endmodule

// File: rtl/cell_line_fetch.sv
// Fetches the next cell row into a line buffer during hblank and streams it out as pixel_on.
module cell_line_fetch #(
    parameter int unsigned RD_LATENCY = automata_vga_pkg::RD_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    cell_line_fetch_if.master mem,
    output logic              pixel_on,
    output logic              fetch_err
);
    import automata_vga_pkg::*;

    fetch_state_t                state_q, state_d;
    logic [5:0]                  widx_q, widx_d;
    logic [9:0]                  row_q, row_d;
    logic                        err_q, err_d;
    logic [RD_LATENCY-1:0]       pv_q, pv_d;
    logic [RD_LATENCY-1:0][5:0]  pidx_q, pidx_d;
    logic [5:0]                  wcnt_q, wcnt_d;
    logic [4:0]                  bcnt_q, bcnt_d;
    logic                        pix_q, pix_d;

    logic [10:0]       tgt_row;
    logic              at_swap, active, pipe_busy;
    logic              swap, invalidate, flush;
    logic              cap_valid;
    logic [5:0]        wcnt_cur;
    logic [4:0]        bcnt_cur;
    logic [WORD_W-1:0] front_word;
    logic              front_valid;

    assign tgt_row = (vcount == 11'(V_TOTAL - 1)) ? '0 : vcount + 11'd1;
    assign at_swap = (hcount == 11'(H_TOTAL - 1));
    assign active  = (hcount < 11'(H_ACTIVE)) && (vcount < 11'(V_ACTIVE));

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        row_d      = row_q;
        err_d      = err_q;
        swap       = 1'b0;
        invalidate = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hcount == 11'(H_ACTIVE - 1) && tgt_row < 11'(V_ACTIVE)) begin
                    state_d = FETCH;
                    widx_d  = '0;
                    row_d   = tgt_row[9:0];
                end
            end
            FETCH: begin
                widx_d = widx_q + 6'd1;
                if (widx_q == 6'(WORDS_PER_ROW - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = DONE;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
        // End of line overrides everything: a late fetch is abandoned, never shown half-written.
        if (at_swap) begin
            state_d = IDLE;
            if (state_q == DONE) begin
                swap = 1'b1;
            end else begin
                invalidate = 1'b1;
                if (state_q != IDLE) begin
                    err_d = 1'b1;
                    flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem.mem_rd   = (state_q == FETCH);
        mem.mem_addr = {row_q, widx_q};
    end

    always_comb begin
        pv_d      = pv_q;
        pidx_d    = pidx_q;
        pv_d[0]   = (state_q == FETCH);
        pidx_d[0] = widx_q;
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end
        if (flush) begin
            pv_d = '0;
        end
        // Only the last stage may still be in flight when DRAIN hands over to DONE.
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i + 1 < RD_LATENCY; i++) begin
            pipe_busy = pipe_busy | pv_q[i];
        end
        cap_valid = pv_q[RD_LATENCY-1] && !at_swap;
    end

    always_comb begin
        wcnt_cur = (hcount == '0) ? '0 : wcnt_q;
        bcnt_cur = (hcount == '0) ? '0 : bcnt_q;
        wcnt_d   = wcnt_cur;
        bcnt_d   = bcnt_cur;
        if (active) begin
            if (bcnt_cur == 5'(WORD_W - 1)) begin
                bcnt_d = '0;
                wcnt_d = wcnt_cur + 6'd1;
            end else begin
                bcnt_d = bcnt_cur + 5'd1;
            end
        end
        pix_d = active && front_valid && front_word[bcnt_cur];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            widx_q  <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            pv_q    <= '0;
            pidx_q  <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            pix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            row_q   <= row_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            pix_q   <= pix_d;
        end
    end

    line_buffer_pp u_line_buffer (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (cap_valid),
        .wr_idx      (pidx_q[RD_LATENCY-1]),
        .wr_data     (mem.mem_q),
        .rd_idx      (wcnt_cur),
        .rd_data     (front_word),
        .front_valid (front_valid),
        .swap        (swap),
        .invalidate  (invalidate)
    );

    assign pixel_on  = pix_q;
    assign fetch_err = err_q;
endmodule

// File: tb/tb_cell_line_fetch.sv
// Directed bench: drives line timing directly, models the cell RAM, and checks reads and pixels.
module tb_cell_line_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount, vcount;
    logic        pixel_on, fetch_err, pixel_on2, fetch_err2;

    cell_line_fetch_if bus();
    cell_line_fetch_if bus2();

    int checks   = 0;
    int failures = 0;
    int cur_h    = 0;
    int cur_v    = 0;

    logic        pat_mode;
    logic [19:0] ram_s1;
    logic        disp_valid, disp_mode, slow_err_exp;
    int unsigned disp_row;

    always #5 clk = ~clk;

    cell_line_fetch u_dut (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .mem       (bus),
        .pixel_on  (pixel_on),
        .fetch_err (fetch_err)
    );

    cell_line_fetch #(.RD_LATENCY(400)) u_slow (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .mem       (bus2),
        .pixel_on  (pixel_on2),
        .fetch_err (fetch_err2)
    );

    function automatic logic [19:0] ram_word(input logic [15:0] a, input logic m);
        return m ? 20'h00001 : (20'(a[15:6]) ^ 20'(a[5:0]));
    endfunction

    // Two-clock RAM for the main instance; the slow instance's data never matters.
    always @(posedge clk) begin
        ram_s1     <= ram_word(bus.mem_addr, pat_mode);
        bus.mem_q  <= ram_s1;
        bus2.mem_q <= 20'hFFFFF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at v=%0d h=%0d: observed=%0h expected=%0h", tag, cur_v, cur_h, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned h, input int unsigned v);
        hcount = 11'(h);
        vcount = 11'(v);
        cur_h  = int'(h);
        cur_v  = int'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int unsigned v, input int rst_at);
        int unsigned tgt = (v == 1065) ? 0 : v + 1;
        bit          fetch_due = (tgt < 1024);
        int          n_rd = 0;
        int          first_h = -1;
        int          last_h = -1;
        int          exp_reads;
        bit          did_rst = 1'b0;
        bit          rst_now;
        logic        exp_pix;
        logic [19:0] w;
        for (int unsigned h = 0; h < 1688; h++) begin
            rst_now = reset;
            cyc(h, v);
            if (rst_now) begin
                chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
                chk("rst_err_slow", 32'(fetch_err2), 32'd0);
                reset        = 1'b0;
                did_rst      = 1'b1;
                slow_err_exp = 1'b0;
            end else if (bus.mem_rd) begin
                chk("rd_addr", 32'(bus.mem_addr), 32'({10'(tgt), 6'(n_rd)}));
                if (first_h < 0) first_h = int'(h);
                last_h = int'(h);
                n_rd++;
                if (n_rd - 1 == rst_at) reset = 1'b1;
            end
            exp_pix = 1'b0;
            if (!rst_now && disp_valid && h < 1280 && v < 1024) begin
                w       = disp_mode ? 20'h00001 : (20'(disp_row) ^ 20'(h / 20));
                exp_pix = w[5'(h % 20)];
            end
            chk("pixel_on", 32'(pixel_on), 32'(exp_pix));
            chk("pixel_on_slow", 32'(pixel_on2), 32'd0);
            if (h == 1686) begin
                chk("err_slow_pre_swap", 32'(fetch_err2), 32'(slow_err_exp));
            end
            if (h == 1687) begin
                if (fetch_due && !did_rst) slow_err_exp = 1'b1;
                chk("err_slow_swap", 32'(fetch_err2), 32'(slow_err_exp));
            end
        end
        exp_reads = (rst_at >= 0) ? rst_at + 1 : (fetch_due ? 64 : 0);
        chk("rd_count", 32'(n_rd), 32'(exp_reads));
        if (exp_reads > 0) begin
            chk("rd_first_h", 32'(first_h), 32'd1279);
            chk("rd_contig", 32'(last_h - first_h + 1), 32'(n_rd));
        end
        chk("fetch_err", 32'(fetch_err), 32'd0);
        disp_valid = fetch_due && !did_rst;
        disp_row   = tgt;
        disp_mode  = pat_mode;
    endtask

    initial begin
        reset        = 1'b1;
        hcount       = '0;
        vcount       = '0;
        pat_mode     = 1'b0;
        disp_valid   = 1'b0;
        disp_mode    = 1'b0;
        disp_row     = 0;
        slow_err_exp = 1'b0;
        repeat (3) cyc(0, 0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("reset_pixel_on", 32'(pixel_on), 32'd0);
        chk("reset_fetch_err", 32'(fetch_err), 32'd0);
        chk("reset_fetch_err_slow", 32'(fetch_err2), 32'd0);
        reset = 1'b0;

        // Frame wrap fetches row 0, then rows 0..5 display the r^w pattern.
        run_line(1065, -1);
        for (int unsigned v = 0; v < 6; v++) run_line(v, -1);

        // Switch RAM to bit0-only words; rows fetched from here on light x%20==0.
        pat_mode = 1'b1;
        for (int unsigned v = 6; v < 9; v++) run_line(v, -1);

        // Bottom of frame: no fetch for row 1024, blank lines dark, wrap refetches row 0.
        run_line(1022, -1);
        run_line(1023, -1);
        run_line(1024, -1);
        run_line(1025, -1);
        run_line(1064, -1);
        run_line(1065, -1);
        run_line(0, -1);

        // Reset at word 30 of the fetch for row 2: row 2 stays dark, row 3 recovers.
        run_line(1, 30);
        run_line(2, -1);
        run_line(3, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
